// File: rtl/screen_draw_pkg.sv
// Shared definitions for the screen drawing engine: op-codes, FSM states, widths.
// No logic of its own; the clamp helper is purely combinational.
// Imported by the engine top and the line stepper.
package screen_draw_pkg;

  localparam int COORD_W = 7;
  localparam int ERR_W   = 10;

  localparam logic [1:0] OP_FILL_RECT = 2'd0;
  localparam logic [1:0] OP_DRAW_LINE = 2'd1;
  localparam logic [1:0] OP_CLEAR     = 2'd2;
  localparam logic [1:0] OP_NOP       = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_DRAW,
    ST_GAP,
    ST_DONE
  } state_t;

  // Coordinates past the right/bottom edge collapse onto the last row/column.
  function automatic logic [COORD_W-1:0] clamp_coord(input logic [COORD_W-1:0] v,
                                                     input int size);
    if (int'(v) >= size) return COORD_W'(size - 1);
    return v;
  endfunction

endpackage

// File: rtl/screen_line_stepper.sv
// Bresenham line walker: holds the current point and error term, advances one pixel per step.
// Latency: init loads in one cycle; each step updates x/y/err in one cycle.
// No backpressure of its own; the owner pulses init/step only when it wants to move.
module screen_line_stepper
  import screen_draw_pkg::*;
(
  input  logic               clk_main,
  input  logic               rst_n,
  input  logic               init,
  input  logic               step,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [COORD_W-1:0] x1,
  input  logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               at_end
);

  logic signed [ERR_W-1:0] err, dx, dy;
  logic signed [ERR_W-1:0] init_dx, init_dy, e2, err_nxt;
  logic                    sx_neg, sy_neg;
  logic [COORD_W-1:0]      xe, ye, x_nxt, y_nxt;

  // Initial deltas from the endpoints, and the per-step update of err/x/y from one shared e2.
  always_comb begin
    init_dx = (x1 >= x0) ? {{(ERR_W-COORD_W){1'b0}}, x1 - x0}
                         : {{(ERR_W-COORD_W){1'b0}}, x0 - x1};
    init_dy = (y1 >= y0) ? -{{(ERR_W-COORD_W){1'b0}}, y1 - y0}
                         : -{{(ERR_W-COORD_W){1'b0}}, y0 - y1};
    e2      = err <<< 1;
    err_nxt = err;
    x_nxt   = x;
    y_nxt   = y;
    if (e2 >= dy) begin
      err_nxt = err_nxt + dy;
      x_nxt   = sx_neg ? x - 1'b1 : x + 1'b1;
    end
    if (e2 <= dx) begin
      err_nxt = err_nxt + dx;
      y_nxt   = sy_neg ? y - 1'b1 : y + 1'b1;
    end
  end

  assign at_end = (x == xe) && (y == ye);

  // Load the line on init, otherwise walk one pixel per step.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      xe     <= '0;
      ye     <= '0;
      err    <= '0;
      dx     <= '0;
      dy     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (init) begin
      x      <= x0;
      y      <= y0;
      xe     <= x1;
      ye     <= y1;
      dx     <= init_dx;
      dy     <= init_dy;
      err    <= init_dx + init_dy;
      sx_neg <= !(x0 < x1);
      sy_neg <= !(y0 < y1);
    end else if (step) begin
      x   <= x_nxt;
      y   <= y_nxt;
      err <= err_nxt;
    end
  end

endmodule

// File: rtl/screen_draw_engine.sv
// Expands one fill/line/clear command into spaced per-pixel framebuffer writes.
// Latency: accept edge, one setup cycle, first write next cycle, then one write every GAP+1 cycles.
// cmd_ready only in IDLE (commands while busy are dropped); enable low freezes everything.
module screen_draw_engine
  import screen_draw_pkg::*;
#(
  parameter int SCREEN_SIZE = 128,
  parameter int GAP         = 1
) (
  input  logic               clk_main,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [15:0]        cmd_color,
  output logic [COORD_W-1:0] pixel_addr_x,
  output logic [COORD_W-1:0] pixel_addr_y,
  output logic               pixel_wr_en,
  output logic [15:0]        pixel_wr_data,
  output logic               busy,
  output logic               done
);

  localparam int GW = (GAP > 1) ? $clog2(GAP + 1) : 1;

  state_t             state, state_nxt;
  logic [1:0]         op_q;
  logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
  logic [15:0]        color_q;
  logic [COORD_W-1:0] xmin, xmax, ymin, ymax, rx, ry;
  logic [COORD_W-1:0] bx_min, bx_max, by_min, by_max;
  logic [COORD_W-1:0] hold_x, hold_y, cur_x, cur_y, ln_x, ln_y;
  logic [15:0]        hold_d;
  logic [GW-1:0]      gap_cnt;
  logic               last_q, ln_at_end, line_init, line_step;
  logic               is_line, rect_last, px_last, wr;

  assign is_line   = (op_q == OP_DRAW_LINE);
  assign rect_last = (rx == xmax) && (ry == ymax);
  assign px_last   = is_line ? ln_at_end : rect_last;
  assign cur_x     = is_line ? ln_x : rx;
  assign cur_y     = is_line ? ln_y : ry;
  assign wr        = (state == ST_DRAW) && enable;

  assign cmd_ready     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE) && enable;
  assign pixel_wr_en   = wr;
  assign pixel_addr_x  = wr ? cur_x : hold_x;
  assign pixel_addr_y  = wr ? cur_y : hold_y;
  assign pixel_wr_data = wr ? color_q : hold_d;

  // Rectangle bounds: CLEAR covers the whole screen, otherwise order the corners.
  always_comb begin
    if (op_q == OP_CLEAR) begin
      bx_min = '0;
      by_min = '0;
      bx_max = COORD_W'(SCREEN_SIZE - 1);
      by_max = COORD_W'(SCREEN_SIZE - 1);
    end else begin
      bx_min = (x0_q < x1_q) ? x0_q : x1_q;
      bx_max = (x0_q < x1_q) ? x1_q : x0_q;
      by_min = (y0_q < y1_q) ? y0_q : y1_q;
      by_max = (y0_q < y1_q) ? y1_q : y0_q;
    end
  end

  // Next state and line-stepper controls; nothing moves while enable is low.
  always_comb begin
    state_nxt = state;
    line_init = 1'b0;
    line_step = 1'b0;
    if (enable) begin
      case (state)
        ST_IDLE:  if (cmd_valid) state_nxt = ST_SETUP;
        ST_SETUP: begin
          state_nxt = (op_q == OP_NOP) ? ST_DONE : ST_DRAW;
          line_init = is_line;
        end
        ST_DRAW: begin
          line_step = is_line && !ln_at_end;
          if (GAP > 0)      state_nxt = ST_GAP;
          else if (px_last) state_nxt = ST_DONE;
        end
        ST_GAP:   if (gap_cnt == GW'(GAP - 1)) state_nxt = last_q ? ST_DONE : ST_DRAW;
        ST_DONE:  state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the command on acceptance, with coordinates clamped to the screen.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_FILL_RECT;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (enable && cmd_valid && (state == ST_IDLE)) begin
      op_q    <= cmd_op;
      x0_q    <= clamp_coord(cmd_x0, SCREEN_SIZE);
      y0_q    <= clamp_coord(cmd_y0, SCREEN_SIZE);
      x1_q    <= clamp_coord(cmd_x1, SCREEN_SIZE);
      y1_q    <= clamp_coord(cmd_y1, SCREEN_SIZE);
      color_q <= cmd_color;
    end
  end

  // Row-major rectangle walk: x first, wrap to xmin and bump y at the end of a row.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      xmin <= '0;
      xmax <= '0;
      ymin <= '0;
      ymax <= '0;
      rx   <= '0;
      ry   <= '0;
    end else if (enable) begin
      if (state == ST_SETUP) begin
        xmin <= bx_min;
        xmax <= bx_max;
        ymin <= by_min;
        ymax <= by_max;
        rx   <= bx_min;
        ry   <= by_min;
      end else if ((state == ST_DRAW) && !is_line && !rect_last) begin
        if (rx == xmax) begin
          rx <= xmin;
          ry <= ry + 1'b1;
        end else begin
          rx <= rx + 1'b1;
        end
      end
    end
  end

  // Gap timer restarts on every write and remembers whether that write was the last.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
      last_q  <= 1'b0;
    end else if (enable) begin
      if (state == ST_DRAW) begin
        gap_cnt <= '0;
        last_q  <= px_last;
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  // Address/data outputs keep the last written values between strobes.
  always_ff @(posedge clk_main or negedge rst_n) begin
    if (!rst_n) begin
      hold_x <= '0;
      hold_y <= '0;
      hold_d <= '0;
    end else if (wr) begin
      hold_x <= cur_x;
      hold_y <= cur_y;
      hold_d <= color_q;
    end
  end

  screen_line_stepper u_line (
    .clk_main (clk_main),
    .rst_n    (rst_n),
    .init     (line_init),
    .step     (line_step),
    .x0       (x0_q),
    .y0       (y0_q),
    .x1       (x1_q),
    .y1       (y1_q),
    .x        (ln_x),
    .y        (ln_y),
    .at_end   (ln_at_end)
  );

endmodule

// File: tb/tb_screen_draw_engine.sv
// Two engines (GAP=0 and GAP=1) share stimulus; each is scored against a queue-based pixel model.
// Timing is tracked in enabled cycles since accept so stalls shift expectations naturally.
// Directed cases first, then randomized rectangles, lines, NOPs and stalls.
module tb_screen_draw_engine;

  logic        clk_main = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'd0;
  logic [6:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [15:0] cmd_color = '0;

  logic        rdy[2], wr_en[2], busy[2], done[2];
  logic [6:0]  ax[2], ay[2];
  logic [15:0] wd[2];

  int checks = 0;
  int errors = 0;
  logic [29:0] expq[$];

  always #5 clk_main = ~clk_main;

  screen_draw_engine #(.SCREEN_SIZE(128), .GAP(0)) u_dut0 (
    .clk_main(clk_main), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(rdy[0]), .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .pixel_addr_x(ax[0]), .pixel_addr_y(ay[0]), .pixel_wr_en(wr_en[0]),
    .pixel_wr_data(wd[0]), .busy(busy[0]), .done(done[0])
  );

  screen_draw_engine #(.SCREEN_SIZE(128), .GAP(1)) u_dut1 (
    .clk_main(clk_main), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid),
    .cmd_ready(rdy[1]), .cmd_op(cmd_op), .cmd_x0(cmd_x0), .cmd_y0(cmd_y0),
    .cmd_x1(cmd_x1), .cmd_y1(cmd_y1), .cmd_color(cmd_color),
    .pixel_addr_x(ax[1]), .pixel_addr_y(ay[1]), .pixel_wr_en(wr_en[1]),
    .pixel_wr_data(wd[1]), .busy(busy[1]), .done(done[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int d = 0; d < 2; d++)
      check(tag, {rdy[d], wr_en[d], busy[d], done[d], ax[d], ay[d], wd[d]}, {1'b1, 33'b0});
  endtask

  // Reference pixel list straight from the drawing rules.
  task automatic build_expected(input logic [1:0] op, input int x0, input int y0,
                                input int x1, input int y1, input logic [15:0] c);
    int xa, xb, ya, yb, dx, dy, sx, sy, err, e2, x, y;
    expq.delete();
    if (op == 2'd3) return;
    if (op == 2'd1) begin
      dx = (x1 > x0) ? x1 - x0 : x0 - x1;
      dy = (y1 > y0) ? y0 - y1 : y1 - y0;
      sx = (x0 < x1) ? 1 : -1;
      sy = (y0 < y1) ? 1 : -1;
      err = dx + dy;
      x = x0;
      y = y0;
      forever begin
        expq.push_back({7'(x), 7'(y), c});
        if (x == x1 && y == y1) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
      return;
    end
    if (op == 2'd2) begin
      xa = 0; xb = 127; ya = 0; yb = 127;
    end else begin
      xa = (x0 < x1) ? x0 : x1; xb = (x0 < x1) ? x1 : x0;
      ya = (y0 < y1) ? y0 : y1; yb = (y0 < y1) ? y1 : y0;
    end
    for (int yy = ya; yy <= yb; yy++)
      for (int xx = xa; xx <= xb; xx++)
        expq.push_back({7'(xx), 7'(yy), c});
  endtask

  // Issue one command and score both engines until each has finished and returned to idle.
  task automatic run_cmd(input logic [1:0] op, input int x0, input int y0, input int x1,
                         input int y1, input logic [15:0] color, input int st_start,
                         input int st_len);
    int n, e, limit;
    int k[2];
    bit dseen[2], fin[2];
    build_expected(op, x0, y0, x1, y1, color);
    n = expq.size();
    for (int d = 0; d < 2; d++) begin
      check("idle_ready", {rdy[d], busy[d]}, 2'b10);
      k[d] = 0; dseen[d] = 1'b0; fin[d] = 1'b0;
    end
    cmd_op = op; cmd_x0 = 7'(x0); cmd_y0 = 7'(y0); cmd_x1 = 7'(x1); cmd_y1 = 7'(y1);
    cmd_color = color; cmd_valid = 1'b1; enable = 1'b1;
    @(posedge clk_main); #1;
    // Junk command while busy: must be ignored, and the latched fields must not change.
    cmd_op = 2'($urandom); cmd_x0 = 7'($urandom); cmd_y0 = 7'($urandom);
    cmd_x1 = 7'($urandom); cmd_y1 = 7'($urandom); cmd_color = 16'($urandom);
    e = 1;
    limit = 12 + 2 * n + st_len;
    for (int c = 1; ; c++) begin
      if (c == 3) cmd_valid = 1'b0;
      enable = !(st_len > 0 && c >= st_start && c < st_start + st_len);
      @(negedge clk_main);
      for (int d = 0; d < 2; d++) begin
        if (!fin[d]) begin
          if (c == 1) check("busy_start", {rdy[d], busy[d]}, 2'b01);
          if (!enable) check("stall_wr", wr_en[d], 1'b0);
          if (wr_en[d]) begin
            if (k[d] < n) begin
              check("wr_cyc", e, 2 + k[d] * (d + 1));
              check("wr_px", {ax[d], ay[d], wd[d]}, expq[k[d]]);
            end else begin
              check("extra_wr", k[d], n - 1);
            end
            k[d]++;
          end
          if (dseen[d]) begin
            check("post_done", {rdy[d], busy[d], done[d]}, 3'b100);
            fin[d] = 1'b1;
          end else if (done[d]) begin
            check("done_cyc", e, 2 + n * (d + 1));
            check("npix", k[d], n);
            dseen[d] = 1'b1;
          end
        end
      end
      if (fin[0] && fin[1]) break;
      if (c >= limit) begin
        check("timeout", 1'b1, 1'b0);
        break;
      end
      if (enable) e++;
      @(posedge clk_main); #1;
    end
    enable = 1'b1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int op, x0, y0, x1, y1, ss, sl;
    enable = 1'b1;
    repeat (2) @(posedge clk_main);
    @(negedge clk_main);
    check_reset_vals("reset");
    #1 rst_n = 1'b1;
    @(posedge clk_main); #1;

    run_cmd(2'd0, 5, 5, 6, 6, 16'hF800, 0, 0);
    run_cmd(2'd0, 6, 6, 5, 5, 16'h1234, 0, 0);
    run_cmd(2'd1, 0, 0, 3, 1, 16'h07E0, 0, 0);
    run_cmd(2'd1, 3, 1, 0, 0, 16'h07E0, 0, 0);
    run_cmd(2'd1, 9, 9, 9, 9, 16'hABCD, 0, 0);
    run_cmd(2'd3, 1, 2, 3, 4, 16'hFFFF, 0, 0);
    run_cmd(2'd0, 0, 10, 3, 10, 16'h5A5A, 4, 3);
    run_cmd(2'd2, 0, 0, 0, 0, 16'h0000, 0, 0);

    // Reset during the third write of a CLEAR.
    cmd_op = 2'd2; cmd_color = 16'h00FF; cmd_valid = 1'b1;
    @(posedge clk_main); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk_main);
    @(negedge clk_main);
    check("rst_3rd_px", {wr_en[0], ax[0], ay[0]}, {1'b1, 7'd2, 7'd0});
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst_async");
    @(posedge clk_main); #1;
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_main);
      check("rst_no_wr", {wr_en[0], wr_en[1]}, 2'b00);
    end
    run_cmd(2'd0, 0, 0, 0, 0, 16'hBEEF, 0, 0);

    for (int i = 0; i < 25; i++) begin
      op = $urandom_range(0, 2);
      if (op == 2) op = 3;
      if ($urandom_range(0, 4) == 0) op = 3 - 2 * $urandom_range(0, 1);
      x0 = $urandom_range(0, 127);
      y0 = $urandom_range(0, 127);
      if (op == 0) begin
        x1 = $urandom_range((x0 > 6) ? x0 - 6 : 0, (x0 < 121) ? x0 + 6 : 127);
        y1 = $urandom_range((y0 > 6) ? y0 - 6 : 0, (y0 < 121) ? y0 + 6 : 127);
      end else begin
        x1 = $urandom_range(0, 127);
        y1 = $urandom_range(0, 127);
      end
      ss = 0; sl = 0;
      if ($urandom_range(0, 2) == 0) begin
        ss = $urandom_range(3, 10);
        sl = $urandom_range(1, 4);
      end
      run_cmd(2'(op), x0, y0, x1, y1, 16'($urandom), ss, sl);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/screen_draw_engine.md
Name: screen_draw_engine

Overview:
Upstream drawing stage for the ST7735 framebuffer controller. Accepts one drawing command at a time (rectangle fill, line, full-screen clear) and expands it into per-pixel framebuffer writes on the controller's pixel_addr_x/pixel_addr_y/pixel_wr_en/pixel_wr_data inputs. Writes are spaced by a programmable gap, so the controller's framebuffer-to-screen read path is never starved.

Parameters:
SCREEN_SIZE, 128, screen width and height in pixels; coordinates are 0..SCREEN_SIZE-1.
GAP, 1, idle cycles inserted after each pixel write (0 = back-to-back writes).

Ports:
clk_main  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  global enable; low freezes the engine
cmd_valid  input  1  command present
cmd_ready  output  1  engine can accept a command (high only in IDLE)
cmd_op  input  2  0=FILL_RECT, 1=DRAW_LINE, 2=CLEAR, 3=reserved (treated as NOP)
cmd_x0, cmd_y0, cmd_x1, cmd_y1  input  7 each  corner or endpoint coordinates
cmd_color  input  16  RGB565 colour
pixel_addr_x, pixel_addr_y  output  7 each  framebuffer write address
pixel_wr_en  output  1  one-cycle framebuffer write strobe
pixel_wr_data  output  16  pixel colour
busy  output  1  high from the accept cycle until the done cycle, inclusive
done  output  1  one-cycle pulse after the last pixel of a command

Behaviour:
- Reset values: cmd_ready=1, pixel_wr_en=0, busy=0, done=0, pixel_addr_x/y=0, pixel_wr_data=0, state=IDLE.
- Reset asserted mid-command aborts the command immediately. No further writes occur.
- Accept condition: cmd_valid && cmd_ready && enable on a rising edge (call this cycle 0). All cmd_* fields are latched. Coordinates >= SCREEN_SIZE are clamped to SCREEN_SIZE-1.
- cmd_valid while busy is ignored; it is neither queued nor acknowledged.
- States: IDLE -> SETUP -> DRAW <-> GAP -> DONE -> IDLE.
- SETUP (cycle 1):
  - FILL_RECT: xmin/xmax = min/max(x0,x1), and likewise for y.
  - CLEAR: treated as FILL_RECT over 0..SCREEN_SIZE-1 on both axes.
  - DRAW_LINE: Bresenham initialisation.
  - NOP: goes straight to DONE.
- DRAW: drives pixel_wr_en=1 for exactly one cycle with the current address and colour. The first write occurs in cycle 2.
- Write spacing: write k occurs in cycle 2+k*(GAP+1). With GAP>0, state goes DRAW -> GAP for GAP cycles, then back to DRAW.
- Rectangle order is row-major: x increments first. When x reaches xmax, x returns to xmin and y increments. The last pixel is (xmax,ymax). Pixel count = (xmax-xmin+1)*(ymax-ymin+1).
- Line algorithm:
  - Initialisation: dx=|x1-x0|, dy=-|y1-y0|, sx/sy=±1, err=dx+dy. err and e2 are 10-bit signed.
  - Per pixel: plot. If (x,y)==(x1,y1), finish. Otherwise e2=2*err; if e2>=dy: err+=dy, x+=sx; if e2<=dx: err+=dx, y+=sy. Both updates use the same e2.
  - Pixel count = max(|dx|,|dy|)+1. A single-point line writes one pixel.
- DONE: done=1 for one cycle, in the cycle after the last write plus GAP cycles. Next cycle the engine is in IDLE with cmd_ready=1 and busy=0.
- enable low:
  - The state, counters and gap timer all hold, and pixel_wr_en is forced to 0.
  - On resume, the pending pixel is written; none is skipped or duplicated.
  - No command is accepted while enable is low.
- pixel_addr_x/y and pixel_wr_data hold their last values when pixel_wr_en=0.

Decomposition:
- Package screen_draw_pkg holds:
  - op-code constants (OP_FILL_RECT, OP_DRAW_LINE, OP_CLEAR);
  - state encoding;
  - COORD_W=7 and ERR_W=10.
- Sub-module screen_line_stepper holds the Bresenham registers (x, y, err, sx, sy, dx, dy) with init/step/at_end signals. The top level owns the FSM, the rectangle counters and the gap timer.

Test Plan:
1. GAP=0, FILL_RECT (5,5)-(6,6), colour 0xF800 -> writes (5,5),(6,5),(5,6),(6,6) in cycles 2..5; done in cycle 6; cmd_ready in cycle 7.
2. GAP=1, FILL_RECT with swapped corners (6,6)-(5,5) -> same four pixels in the same order, in cycles 2,4,6,8; done in cycle 10.
3. GAP=0, DRAW_LINE (0,0)-(3,1), colour 0x07E0 -> writes (0,0),(1,0),(2,1),(3,1). Also DRAW_LINE (3,1)-(0,0) -> (3,1),(2,1),(1,0),(0,0).
4. GAP=0, CLEAR, colour 0x0000 -> exactly 16384 writes; first (0,0), 128th (127,0), last (127,127); done follows.
5. FILL_RECT 4x1 with enable dropped for 3 cycles after the 2nd write -> no writes during the stall; exactly 4 unique writes in order; done is delayed by 3 cycles.
6. rst_n pulsed low during the 3rd pixel of a CLEAR -> outputs return to reset values asynchronously; no further writes; a new FILL_RECT (0,0)-(0,0) then writes only (0,0).
